// File: rtl/control_loop_sequencer_pkg.sv
// Shared widths, state encoding and saturation limits for the control-loop sequencer.
// Optional feature macro: CONTROL_LOOP_SLEW_LIMIT_EN (per-iteration adjval clamp of +/-MAX_STEP).
package control_loop_sequencer_pkg;

  localparam int ADC_WID_DEF         = 18;
  localparam int DAC_DATA_WID_DEF    = 20;
  localparam int CONSTS_WID_DEF      = 48;
  localparam int CYCLE_COUNT_WID_DEF = 18;
  localparam int DELAY_WID_DEF       = 16;
  localparam int MAX_STEP            = 4096;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ADC_ARM     = 3'd1;
  localparam logic [2:0] ST_ADC_DISARM  = 3'd2;
  localparam logic [2:0] ST_MATH_ARM    = 3'd3;
  localparam logic [2:0] ST_MATH_DISARM = 3'd4;
  localparam logic [2:0] ST_DAC_ARM     = 3'd5;
  localparam logic [2:0] ST_DAC_DISARM  = 3'd6;
  localparam logic [2:0] ST_DELAY       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_ADC_ARM     = ST_ADC_ARM,
    S_ADC_DISARM  = ST_ADC_DISARM,
    S_MATH_ARM    = ST_MATH_ARM,
    S_MATH_DISARM = ST_MATH_DISARM,
    S_DAC_ARM     = ST_DAC_ARM,
    S_DAC_DISARM  = ST_DAC_DISARM,
    S_DELAY       = ST_DELAY
  } state_e;

  // Two's-complement limits of the default-width DAC word.
  localparam logic signed [DAC_DATA_WID_DEF-1:0] DAC_SAT_MAX = {1'b0, {(DAC_DATA_WID_DEF-1){1'b1}}};
  localparam logic signed [DAC_DATA_WID_DEF-1:0] DAC_SAT_MIN = {1'b1, {(DAC_DATA_WID_DEF-1){1'b0}}};

endpackage

// File: rtl/control_loop_sequencer_if.sv
// ADC / math / DAC handshake and operand bundle. master = sequencer, slave = peripherals.
interface control_loop_sequencer_if
  import control_loop_sequencer_pkg::*;
#(
  parameter int ADC_WID         = ADC_WID_DEF,
  parameter int DAC_DATA_WID    = DAC_DATA_WID_DEF,
  parameter int CONSTS_WID      = CONSTS_WID_DEF,
  parameter int CYCLE_COUNT_WID = CYCLE_COUNT_WID_DEF,
  parameter int DELAY_WID       = DELAY_WID_DEF
);
  logic                       adc_arm;
  logic                       adc_fin;
  logic [ADC_WID-1:0]         adc_data;
  logic                       math_arm;
  logic                       math_fin;
  logic [ADC_WID-1:0]         math_setpt;
  logic [ADC_WID-1:0]         math_measured;
  logic [CONSTS_WID-1:0]      math_cl_P;
  logic [CONSTS_WID-1:0]      math_cl_I;
  logic [CONSTS_WID-1:0]      math_e_prev;
  logic [CYCLE_COUNT_WID-1:0] math_cycles;
  logic [DELAY_WID-1:0]       math_dely;
  logic [CONSTS_WID-1:0]      math_e_cur;
  logic [DAC_DATA_WID-1:0]    math_adjval;
  logic                       dac_arm;
  logic                       dac_fin;
  logic [DAC_DATA_WID-1:0]    dac_data;

  modport master (
    output adc_arm, input adc_fin, input adc_data,
    output math_arm, input math_fin,
    output math_setpt, math_measured, math_cl_P, math_cl_I, math_e_prev, math_cycles, math_dely,
    input math_e_cur, input math_adjval,
    output dac_arm, input dac_fin, output dac_data
  );

  modport slave (
    input adc_arm, output adc_fin, output adc_data,
    input math_arm, output math_fin,
    input math_setpt, math_measured, math_cl_P, math_cl_I, math_e_prev, math_cycles, math_dely,
    output math_e_cur, output math_adjval,
    input dac_arm, output dac_fin, input dac_data
  );
endinterface

// File: rtl/control_loop_sequencer_sat_add_signed.sv
// Parametric signed saturating adder: adds at W+1 bits, then clamps into [MIN_V, MAX_V].
// Used both for DAC accumulation (full-range limits) and for the optional slew clamp (b_i = 0).
module sat_add_signed #(
  parameter int                  W     = 20,
  parameter logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}}
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);
  localparam logic signed [W:0] MAX_X = (W+1)'(MAX_V);
  localparam logic signed [W:0] MIN_X = (W+1)'(MIN_V);

  logic signed [W:0] sum_s;

  // Widened sum cannot overflow; clamp it back into the W-bit window.
  always_comb begin
    sum_s = (W+1)'(a_i) + (W+1)'(b_i);
    if (sum_s > MAX_X) begin
      y_o = MAX_V;
    end else if (sum_s < MIN_X) begin
      y_o = MIN_V;
    end else begin
      y_o = sum_s[W-1:0];
    end
  end
endmodule

// File: rtl/control_loop_sequencer.sv
// Iteration sequencer around control_loop_math: ADC sample -> math -> saturated DAC update -> delay.
// Optional feature macro: CONTROL_LOOP_SLEW_LIMIT_EN clamps adjval to +/-MAX_STEP before accumulation.
module control_loop_sequencer
  import control_loop_sequencer_pkg::*;
#(
  parameter int ADC_WID         = ADC_WID_DEF,
  parameter int DAC_DATA_WID    = DAC_DATA_WID_DEF,
  parameter int CONSTS_WID      = CONSTS_WID_DEF,
  parameter int CYCLE_COUNT_WID = CYCLE_COUNT_WID_DEF,
  parameter int DELAY_WID       = DELAY_WID_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [ADC_WID-1:0]     setpt_in,
  input  logic [CONSTS_WID-1:0]  cl_P_in,
  input  logic [CONSTS_WID-1:0]  cl_I_in,
  input  logic [DELAY_WID-1:0]   dely_in,
  output logic                   busy,
  control_loop_sequencer_if.master bus
);
  state_e                     state_q, state_d;
  logic                       run_q;
  logic                       adc_arm_q, math_arm_q, dac_arm_q, busy_q;
  logic [ADC_WID-1:0]         setpt_q, measured_q;
  logic [CONSTS_WID-1:0]      p_q, i_q, e_prev_q, e_cur_q;
  logic [DELAY_WID-1:0]       dely_q, dly_cnt_q;
  logic [CYCLE_COUNT_WID-1:0] cnt_q, cycles_q;
  logic                       first_q;
  logic [DAC_DATA_WID-1:0]    dac_data_q;
  logic signed [DAC_DATA_WID-1:0] adj_s, acc_s;
  logic start_s, rise_s, adc_take_s, math_take_s, e_commit_s, dly_load_s, dly_dec_s;

`ifdef CONTROL_LOOP_SLEW_LIMIT_EN
  localparam logic signed [DAC_DATA_WID-1:0] STEP_HI = DAC_DATA_WID'(MAX_STEP);
  localparam logic signed [DAC_DATA_WID-1:0] STEP_LO = -STEP_HI;
  sat_add_signed #(.W(DAC_DATA_WID), .MAX_V(STEP_HI), .MIN_V(STEP_LO)) u_slew (
    .a_i(bus.math_adjval), .b_i({DAC_DATA_WID{1'b0}}), .y_o(adj_s));
`else
  assign adj_s = bus.math_adjval;
`endif

  sat_add_signed #(.W(DAC_DATA_WID)) u_acc (.a_i(dac_data_q), .b_i(adj_s), .y_o(acc_s));

  // Next-state decode and single-cycle datapath strobes.
  always_comb begin
    state_d     = state_q;
    start_s     = 1'b0;
    adc_take_s  = 1'b0;
    math_take_s = 1'b0;
    e_commit_s  = 1'b0;
    dly_load_s  = 1'b0;
    dly_dec_s   = 1'b0;
    case (state_q)
      S_IDLE:        if (run) begin start_s = 1'b1; state_d = S_ADC_ARM; end
                     else state_d = S_IDLE;
      S_ADC_ARM:     if (bus.adc_fin) begin adc_take_s = 1'b1; state_d = S_ADC_DISARM; end
                     else state_d = S_ADC_ARM;
      S_ADC_DISARM:  if (!bus.adc_fin) state_d = S_MATH_ARM;
                     else state_d = S_ADC_DISARM;
      S_MATH_ARM:    if (bus.math_fin) begin math_take_s = 1'b1; state_d = S_MATH_DISARM; end
                     else state_d = S_MATH_ARM;
      S_MATH_DISARM: if (!bus.math_fin) begin e_commit_s = 1'b1; state_d = S_DAC_ARM; end
                     else state_d = S_MATH_DISARM;
      S_DAC_ARM:     if (bus.dac_fin) state_d = S_DAC_DISARM;
                     else state_d = S_DAC_ARM;
      // A zero delay skips the DELAY state entirely.
      S_DAC_DISARM:  if (bus.dac_fin) state_d = S_DAC_DISARM;
                     else if (dely_q != '0) begin dly_load_s = 1'b1; state_d = S_DELAY; end
                     else if (run) begin start_s = 1'b1; state_d = S_ADC_ARM; end
                     else state_d = S_IDLE;
      S_DELAY:       if (dly_cnt_q != '0) dly_dec_s = 1'b1;
                     else if (run) begin start_s = 1'b1; state_d = S_ADC_ARM; end
                     else state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Leaving IDLE on a fresh run assertion restarts the error history and cycle count.
  assign rise_s = start_s && (state_q == S_IDLE) && !run_q;

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      adc_arm_q  <= 1'b0;
      math_arm_q <= 1'b0;
      dac_arm_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run;
      adc_arm_q  <= (state_d == S_ADC_ARM);
      math_arm_q <= (state_d == S_MATH_ARM);
      dac_arm_q  <= (state_d == S_DAC_ARM);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // Per-iteration latches of the externally supplied operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setpt_q <= '0;
      p_q     <= '0;
      i_q     <= '0;
      dely_q  <= '0;
    end else if (start_s) begin
      setpt_q <= setpt_in;
      p_q     <= cl_P_in;
      i_q     <= cl_I_in;
      dely_q  <= dely_in;
    end
  end

  // Elapsed-cycle counter (saturating) and ADC sample capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cycles_q   <= '0;
      measured_q <= '0;
      first_q    <= 1'b0;
    end else if (rise_s) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else if (adc_take_s) begin
      measured_q <= bus.adc_data;
      cycles_q   <= first_q ? '0 : cnt_q;
      cnt_q      <= '0;
      first_q    <= 1'b0;
    end else if ((state_q != S_IDLE) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CYCLE_COUNT_WID'(1);
    end
  end

  // Error history and DAC accumulator; e_prev only moves after math_fin falls so operands stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_prev_q   <= '0;
      e_cur_q    <= '0;
      dac_data_q <= '0;
    end else if (rise_s) begin
      e_prev_q <= '0;
      e_cur_q  <= '0;
    end else if (math_take_s) begin
      e_cur_q    <= bus.math_e_cur;
      dac_data_q <= acc_s;
    end else if (e_commit_s) begin
      e_prev_q <= e_cur_q;
    end
  end

  // Inter-iteration delay countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt_q <= '0;
    end else if (dly_load_s) begin
      dly_cnt_q <= dely_q - DELAY_WID'(1);
    end else if (dly_dec_s) begin
      dly_cnt_q <= dly_cnt_q - DELAY_WID'(1);
    end
  end

  assign busy              = busy_q;
  assign bus.adc_arm       = adc_arm_q;
  assign bus.math_arm      = math_arm_q;
  assign bus.dac_arm       = dac_arm_q;
  assign bus.dac_data      = dac_data_q;
  assign bus.math_setpt    = setpt_q;
  assign bus.math_measured = measured_q;
  assign bus.math_cl_P     = p_q;
  assign bus.math_cl_I     = i_q;
  assign bus.math_e_prev   = e_prev_q;
  assign bus.math_cycles   = cycles_q;
  assign bus.math_dely     = dely_q;
endmodule

// File: tb/tb_control_loop_sequencer.sv
// Self-checking bench for control_loop_sequencer: randomized ADC/math/DAC service times and operands
// against a behavioural model. The cycle counter is narrowed to 10 bits so saturation is reachable.
module tb_control_loop_sequencer;
  import control_loop_sequencer_pkg::*;

  localparam int AW = ADC_WID_DEF;
  localparam int DW = DAC_DATA_WID_DEF;
  localparam int KW = CONSTS_WID_DEF;
  localparam int LW = DELAY_WID_DEF;
  localparam int CW = 10;
  localparam int CYC_MAX = (1 << CW) - 1;
  localparam int TMO = 4000;
  localparam longint DAC_HI = (longint'(1) << (DW - 1)) - 1;
  localparam longint DAC_LO = -(longint'(1) << (DW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [AW-1:0] setpt_in = '0;
  logic [KW-1:0] cl_P_in = '0, cl_I_in = '0;
  logic [LW-1:0] dely_in = '0;
  logic busy;

  control_loop_sequencer_if #(.CYCLE_COUNT_WID(CW)) bus_if ();

  control_loop_sequencer #(.CYCLE_COUNT_WID(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .setpt_in(setpt_in), .cl_P_in(cl_P_in),
    .cl_I_in(cl_I_in), .dely_in(dely_in), .busy(busy), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vectors = 0, n_miscompares = 0;
  longint dac_m = 0;
  logic [KW-1:0] eprev_m = '0;
  logic [LW-1:0] last_dely = '0;
  int cap_prev = 0, dac_writes = 0;
  bit first_m = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0: return bus_if.adc_arm;
      1: return bus_if.math_arm;
      2: return bus_if.dac_arm;
      default: return busy;
    endcase
  endfunction

  // Bounded wait for a level; an expired wait shows up as a failed comparison.
  task automatic wait_level(input string tag, input int sel, input logic lvl, output int n);
    n = 0;
    while (sig_of(sel) !== lvl && n < TMO) begin
      tick();
      n++;
    end
    check_val(tag, sig_of(sel), lvl);
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic [DW-1:0] to_dw(input longint v);
    return v[DW-1:0];
  endfunction

  // One full iteration: service ADC, math and DAC handshakes and check against the model.
  task automatic iterate(input logic [AW-1:0] adc_v, input logic [DW-1:0] adj_v, input int stall,
                         input bit gap_chk, input bit drop_run, input bit reseed);
    int n, cap, ecyc;
    longint adj_e;
    logic [AW-1:0] e_setpt;
    logic [KW-1:0] e_p, e_i, ecur;
    logic [LW-1:0] e_dely;
    logic [DW-1:0] dexp;
    wait_level("adc_arm_on", 0, 1'b1, n);
    if (gap_chk) check_val("idle_clks", 64'(n - 1), 64'(last_dely));
    e_setpt = setpt_in; e_p = cl_P_in; e_i = cl_I_in; e_dely = dely_in;
    if (drop_run) run = 1'b0;
    if (reseed) begin
      setpt_in = AW'($urandom);
      cl_P_in  = KW'({$urandom(), $urandom()});
      cl_I_in  = KW'({$urandom(), $urandom()});
      dely_in  = LW'($urandom_range(0, 6));
    end
    repeat ($urandom_range(0, 3)) tick();
    bus_if.adc_data = adc_v; bus_if.adc_fin = 1'b1;
    tick();
    cap = cyc;
    check_val("adc_arm_off", bus_if.adc_arm, 1'b0);
    repeat ($urandom_range(0, 2)) tick();
    bus_if.adc_fin = 1'b0;
    wait_level("math_arm_on", 1, 1'b1, n);
    ecyc = first_m ? 0 : (((cap - cap_prev - 1) > CYC_MAX) ? CYC_MAX : (cap - cap_prev - 1));
    first_m = 1'b0;
    cap_prev = cap;
    check_val("measured", bus_if.math_measured, adc_v);
    check_val("setpt", bus_if.math_setpt, e_setpt);
    check_val("cl_P", bus_if.math_cl_P, e_p);
    check_val("cl_I", bus_if.math_cl_I, e_i);
    check_val("dely", bus_if.math_dely, e_dely);
    check_val("e_prev", bus_if.math_e_prev, eprev_m);
    check_val("cycles", bus_if.math_cycles, 64'(ecyc));
    repeat (stall) tick();
    ecur = KW'({$urandom(), $urandom()});
    bus_if.math_e_cur = ecur; bus_if.math_adjval = adj_v; bus_if.math_fin = 1'b1;
    tick();
    adj_e = longint'($signed(adj_v));
`ifdef CONTROL_LOOP_SLEW_LIMIT_EN
    adj_e = clampl(adj_e, -longint'(MAX_STEP), longint'(MAX_STEP));
`endif
    dac_m = clampl(dac_m + adj_e, DAC_LO, DAC_HI);
    dexp = to_dw(dac_m);
    check_val("dac_data", bus_if.dac_data, dexp);
    check_val("math_arm_off", bus_if.math_arm, 1'b0);
    check_val("e_prev_hold", bus_if.math_e_prev, eprev_m);
    repeat ($urandom_range(0, 2)) tick();
    bus_if.math_fin = 1'b0;
    eprev_m = ecur;
    wait_level("dac_arm_on", 2, 1'b1, n);
    check_val("dac_at_arm", bus_if.dac_data, dexp);
    repeat ($urandom_range(0, 3)) tick();
    bus_if.dac_fin = 1'b1;
    tick();
    dac_writes++;
    check_val("dac_arm_off", bus_if.dac_arm, 1'b0);
    repeat ($urandom_range(0, 2)) tick();
    bus_if.dac_fin = 1'b0;
    last_dely = e_dely;
  endtask

  initial begin
    int n, w;
    bus_if.adc_fin = 1'b0; bus_if.adc_data = '0;
    bus_if.math_fin = 1'b0; bus_if.math_e_cur = '0; bus_if.math_adjval = '0;
    bus_if.dac_fin = 1'b0;
    repeat (3) tick();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_adc_arm", bus_if.adc_arm, 1'b0);
    check_val("rst_math_arm", bus_if.math_arm, 1'b0);
    check_val("rst_dac_arm", bus_if.dac_arm, 1'b0);
    check_val("rst_dac_data", bus_if.dac_data, '0);
    check_val("rst_e_prev", bus_if.math_e_prev, '0);
    check_val("rst_cycles", bus_if.math_cycles, '0);
    rst_n = 1'b1;
    tick();

    // Nominal: setpt 100, measured 40, adjval +5, dely 3.
    setpt_in = 18'd100; dely_in = 16'd3;
    cl_P_in = KW'({$urandom(), $urandom()}); cl_I_in = KW'({$urandom(), $urandom()});
    run = 1'b1; first_m = 1'b1; eprev_m = '0;
    iterate(18'd40, 20'd5, 2, 1'b0, 1'b0, 1'b0);
    iterate(18'd40, 20'd5, 1, 1'b1, 1'b0, 1'b0);

    // Accumulator saturation at both rails, then a large step.
    iterate(AW'($urandom), to_dw(524276), 0, 1'b1, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(10), 0, 1'b1, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(-524287), 0, 1'b1, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(-524287), 0, 1'b1, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(-10), 0, 1'b1, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(10000), 0, 1'b1, 1'b0, 1'b0);

    // Randomized iterations with changing operands and delays.
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) iterate(AW'($urandom), DW'($urandom), $urandom_range(0, 4), 1'b1, 1'b0, 1'b1);
      else iterate(AW'($urandom), to_dw(longint'($urandom_range(0, 400)) - 200),
                   $urandom_range(0, 4), 1'b1, 1'b0, 1'b1);
    end

    // run dropped during ADC_ARM: iteration completes, one DAC write, then IDLE.
    w = dac_writes;
    iterate(AW'($urandom), to_dw(longint'($urandom_range(0, 100))), 1, 1'b1, 1'b1, 1'b0);
    wait_level("busy_low", 3, 1'b0, n);
    repeat (4) tick();
    check_val("dac_writes_once", 64'(dac_writes - w), 64'd1);
    check_val("idle_adc_arm", bus_if.adc_arm, 1'b0);
    check_val("idle_busy", busy, 1'b0);

    // Fresh enable reports cycles 0; a long math stall saturates the next count.
    run = 1'b1; first_m = 1'b1; eprev_m = '0;
    iterate(AW'($urandom), to_dw(3), 1100, 1'b0, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(3), 0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while MATH_ARM is active.
    wait_level("adc_arm_pre_rst", 0, 1'b1, n);
    bus_if.adc_data = AW'($urandom); bus_if.adc_fin = 1'b1;
    tick();
    bus_if.adc_fin = 1'b0;
    wait_level("math_arm_pre_rst", 1, 1'b1, n);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_math_arm", bus_if.math_arm, 1'b0);
    check_val("arst_adc_arm", bus_if.adc_arm, 1'b0);
    check_val("arst_dac_arm", bus_if.dac_arm, 1'b0);
    check_val("arst_dac_data", bus_if.dac_data, '0);
    check_val("arst_busy", busy, 1'b0);
    run = 1'b0;
    dac_m = 0; eprev_m = '0;
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_busy", busy, 1'b0);
    check_val("post_rst_adc_arm", bus_if.adc_arm, 1'b0);

    // Re-enable after reset and run one last iteration out to IDLE.
    run = 1'b1; first_m = 1'b1;
    iterate(AW'($urandom), to_dw(-77), 0, 1'b0, 1'b0, 1'b0);
    iterate(AW'($urandom), to_dw(21), 0, 1'b1, 1'b1, 1'b0);
    wait_level("final_busy_low", 3, 1'b0, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
